// File: rtl/axi4_pkg.sv
// Shared AXI4-lite constants and the IRAM slave state type.
package axi4_pkg;

    localparam int AXI_AWIDTH = 32;
    localparam int AXI_DWIDTH = 32;
    localparam int IRAM_BYTES = 131072;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_RESP,
        RD_MEM,
        RD_RESP
    } iram_state_t;

endpackage

// File: rtl/iram_bram.sv
// Single-port synchronous RAM with per-byte write enables and 1-cycle read
// latency, coded in the shape block-RAM inference expects.
module iram_bram
    import axi4_pkg::*;
#(
    parameter int    DWIDTH    = AXI_DWIDTH,
    parameter int    MEM_BYTES = IRAM_BYTES,
    parameter string INIT_FILE = "",
    localparam int   WAW       = $clog2(MEM_BYTES) - 2
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [3:0]        i_we,
    input  logic [WAW-1:0]    i_addr,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [0:MEM_BYTES/4-1];

    // NOTE: the array has no reset branch; a reset on storage would stop block-RAM
    // inference and would also wipe contents that must survive resetn.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/axi4_iram_slave.sv
// AXI4-lite slave in front of the on-chip IRAM: one transaction at a time,
// byte-strobed writes, two-cycle registered reads.
module axi4_iram_slave
    import axi4_pkg::*;
#(
    parameter int    AWIDTH    = AXI_AWIDTH,
    parameter int    DWIDTH    = AXI_DWIDTH,
    parameter int    MEM_BYTES = IRAM_BYTES,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [AWIDTH-1:0] axi_awaddr,
    input  logic [2:0]        axi_awprot,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    input  logic [DWIDTH-1:0] axi_wdata,
    input  logic [3:0]        axi_wstrb,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    input  logic [AWIDTH-1:0] axi_araddr,
    input  logic [2:0]        axi_arprot,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic [DWIDTH-1:0] axi_rdata
);

    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int WAW    = MEM_AW - 2;

    iram_state_t       r_state, w_next;
    logic              r_out_en;
    logic              r_rd_wait;
    logic [WAW-1:0]    r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [DWIDTH-1:0] r_rdata;

    logic              w_out_en;
    logic              w_arready, w_awready, w_wready, w_bvalid, w_rvalid;
    logic              w_cap_ar, w_cap_aw, w_cap_w, w_rd_load;
    logic              w_ram_en;
    logic [3:0]        w_ram_we;
    logic [WAW-1:0]    w_ram_addr;
    logic [DWIDTH-1:0] w_ram_wdata;
    logic [DWIDTH-1:0] w_ram_q;

    // Interface stays silent while resetn is low and for one cycle after it.
    assign w_out_en = resetn & r_out_en;

    // NOTE: every signal gets its default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next      = r_state;
        w_arready   = 1'b0;
        w_awready   = 1'b0;
        w_wready    = 1'b0;
        w_bvalid    = 1'b0;
        w_rvalid    = 1'b0;
        w_cap_ar    = 1'b0;
        w_cap_aw    = 1'b0;
        w_cap_w     = 1'b0;
        w_rd_load   = 1'b0;
        w_ram_en    = 1'b0;
        w_ram_we    = 4'b0000;
        w_ram_addr  = r_addr;
        w_ram_wdata = r_wdata;
        if (w_out_en) begin
            unique case (r_state)
                IDLE: begin
                    w_arready = 1'b1;
                    w_awready = ~axi_arvalid;
                    w_wready  = ~axi_arvalid;
                    if (axi_arvalid) begin
                        w_cap_ar = 1'b1;
                        w_next   = RD_MEM;
                    end else if (axi_awvalid && axi_wvalid) begin
                        w_ram_en    = 1'b1;
                        w_ram_we    = axi_wstrb;
                        w_ram_addr  = axi_awaddr[MEM_AW-1:2];
                        w_ram_wdata = axi_wdata;
                        w_next      = WR_RESP;
                    end else if (axi_awvalid) begin
                        w_cap_aw = 1'b1;
                        w_next   = WR_WAIT_W;
                    end else if (axi_wvalid) begin
                        w_cap_w = 1'b1;
                        w_next  = WR_WAIT_AW;
                    end
                end
                WR_WAIT_W: begin
                    w_wready = 1'b1;
                    if (axi_wvalid) begin
                        w_ram_en    = 1'b1;
                        w_ram_we    = axi_wstrb;
                        w_ram_wdata = axi_wdata;
                        w_next      = WR_RESP;
                    end
                end
                WR_WAIT_AW: begin
                    w_awready = 1'b1;
                    if (axi_awvalid) begin
                        w_ram_en   = 1'b1;
                        w_ram_we   = r_wstrb;
                        w_ram_addr = axi_awaddr[MEM_AW-1:2];
                        w_next     = WR_RESP;
                    end
                end
                WR_RESP: begin
                    w_bvalid = 1'b1;
                    if (axi_bready) w_next = IDLE;
                end
                RD_MEM: begin
                    // First cycle drives the RAM read, second cycle captures its output.
                    w_ram_en = 1'b1;
                    if (r_rd_wait) begin
                        w_rd_load = 1'b1;
                        w_next    = RD_RESP;
                    end
                end
                RD_RESP: begin
                    w_rvalid = 1'b1;
                    if (axi_rready) w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_out_en  <= 1'b0;
            r_rd_wait <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
        end else begin
            r_state   <= w_next;
            r_out_en  <= 1'b1;
            r_rd_wait <= (r_state == RD_MEM) && !r_rd_wait;
            if (w_cap_ar) r_addr <= axi_araddr[MEM_AW-1:2];
            if (w_cap_aw) r_addr <= axi_awaddr[MEM_AW-1:2];
            if (w_cap_w) begin
                r_wdata <= axi_wdata;
                r_wstrb <= axi_wstrb;
            end
            if (w_rd_load) r_rdata <= w_ram_q;
        end
    end

    iram_bram #(
        .DWIDTH    (DWIDTH),
        .MEM_BYTES (MEM_BYTES),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    assign axi_arready = w_arready;
    assign axi_awready = w_awready;
    assign axi_wready  = w_wready;
    assign axi_bvalid  = w_bvalid;
    assign axi_rvalid  = w_rvalid;
    assign axi_rdata   = w_out_en ? r_rdata : '0;

    // Address bits outside the word index and the prot fields have no effect.
    logic w_unused;
    assign w_unused = ^{axi_awprot, axi_arprot,
                        axi_awaddr[AWIDTH-1:MEM_AW], axi_awaddr[1:0],
                        axi_araddr[AWIDTH-1:MEM_AW], axi_araddr[1:0]};

endmodule

// File: tb/tb_axi4_iram_slave.sv
// Self-checking bench for axi4_iram_slave: directed protocol scenarios followed
// by randomized traffic checked against a word-array model of the IRAM.
module tb_axi4_iram_slave;
    import axi4_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] model [int];

    always #5 clk = ~clk;

    axi4_iram_slave dut (
        .clk         (clk),
        .resetn      (resetn),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_rdata   (axi_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_arready"}, 32'(axi_arready), 32'd0);
        check({tag, "_awready"}, 32'(axi_awready), 32'd0);
        check({tag, "_wready"},  32'(axi_wready),  32'd0);
        check({tag, "_bvalid"},  32'(axi_bvalid),  32'd0);
        check({tag, "_rvalid"},  32'(axi_rvalid),  32'd0);
        check({tag, "_rdata"},   axi_rdata,        32'd0);
    endtask

    // The IRAM wraps every IRAM_BYTES; within it, four bytes form one word.
    function automatic int word_of(input logic [31:0] a);
        return int'(a % IRAM_BYTES) / 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mk_addr(input int idx);
        return ($urandom & 32'hFFFE_0000) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // lead > 0: W goes out that many cycles before AW; lead < 0: AW goes first.
    // Entered and left in the low clock phase with the slave idle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int bdelay,
                            input bit ar_hold, input logic [31:0] ar_addr);
        bit aw_done = 0, w_done = 0, aw_f, w_f;
        int cyc = 0;
        int t_aw = (lead > 0) ? lead : 0;
        int t_w  = (lead < 0) ? -lead : 0;
        int key  = word_of(a);
        while (!(aw_done && w_done) && cyc < 40) begin
            axi_awvalid = !aw_done && (cyc >= t_aw);
            axi_awaddr  = a;
            axi_wvalid  = !w_done && (cyc >= t_w);
            axi_wdata   = d;
            axi_wstrb   = s;
            #1;
            check("wr_awready", 32'(axi_awready), 32'(!aw_done));
            check("wr_wready",  32'(axi_wready),  32'(!w_done));
            check("wr_bvalid_early", 32'(axi_bvalid), 32'd0);
            aw_f = axi_awvalid && axi_awready;
            w_f  = axi_wvalid && axi_wready;
            @(posedge clk);
            aw_done |= aw_f;
            w_done  |= w_f;
            @(negedge clk);
            cyc++;
        end
        check("wr_complete", 32'({aw_done, w_done}), 32'b11);
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        if (aw_done && w_done)
            model[key] = merge(model.exists(key) ? model[key] : 32'hxxxx_xxxx, d, s);
        if (ar_hold) begin
            axi_arvalid = 1'b1;
            axi_araddr  = ar_addr;
        end
        for (int i = 0; i <= bdelay; i++) begin
            #1;
            check("wr_bvalid", 32'(axi_bvalid), 32'd1);
            check("wr_resp_arready", 32'(axi_arready), 32'd0);
            check("wr_resp_awready", 32'(axi_awready), 32'd0);
            @(negedge clk);
        end
        axi_bready = 1'b1;
        #1;
        check("wr_bvalid_hs", 32'(axi_bvalid), 32'd1);
        @(negedge clk);
        axi_bready = 1'b0;
        #1;
        check("wr_bvalid_clear", 32'(axi_bvalid), 32'd0);
        check("wr_idle_arready", 32'(axi_arready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int rdelay);
        axi_arvalid = 1'b1;
        axi_araddr  = a;
        #1;
        check("rd_arready", 32'(axi_arready), 32'd1);
        @(negedge clk);
        axi_arvalid = 1'b0;
        #1;
        check("rd_lat1_rvalid", 32'(axi_rvalid), 32'd0);
        check("rd_busy_awready", 32'(axi_awready), 32'd0);
        @(negedge clk);
        #1;
        check("rd_lat2_rvalid", 32'(axi_rvalid), 32'd0);
        @(negedge clk);
        #1;
        check("rd_rvalid", 32'(axi_rvalid), 32'd1);
        check("rd_rdata", axi_rdata, exp);
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clk);
            #1;
            check("rd_hold_rvalid", 32'(axi_rvalid), 32'd1);
            check("rd_hold_rdata", axi_rdata, exp);
        end
        @(negedge clk);
        axi_rready = 1'b1;
        #1;
        check("rd_rvalid_hs", 32'(axi_rvalid), 32'd1);
        @(negedge clk);
        axi_rready = 1'b0;
        #1;
        check("rd_rvalid_clear", 32'(axi_rvalid), 32'd0);
        check("rd_idle_arready", 32'(axi_arready), 32'd1);
    endtask

    initial begin
        #400000;
        $error("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pool [16];
        logic [31:0] a;

        resetn      = 1'b0;
        axi_awvalid = 1'b0;  axi_awaddr = '0;  axi_awprot = 3'($urandom);
        axi_wvalid  = 1'b0;  axi_wdata  = '0;  axi_wstrb  = '0;
        axi_bready  = 1'b0;
        axi_arvalid = 1'b0;  axi_araddr = '0;  axi_arprot = 3'($urandom);
        axi_rready  = 1'b0;

        // Reset cycle and the cycle after it: silent outputs, even with requests pending.
        @(negedge clk);
        axi_arvalid = 1'b1;  axi_awvalid = 1'b1;  axi_wvalid = 1'b1;  axi_wstrb = 4'hF;
        #1;
        check_zero("rst_during");
        resetn = 1'b1;
        #1;
        check_zero("rst_after");
        @(negedge clk);
        axi_arvalid = 1'b0;  axi_awvalid = 1'b0;  axi_wvalid = 1'b0;
        #1;
        check("post_rst_arready", 32'(axi_arready), 32'd1);
        check("post_rst_awready", 32'(axi_awready), 32'd1);
        check("post_rst_bvalid",  32'(axi_bvalid),  32'd0);

        // Full write, then read back.
        do_write(32'h100, 32'hDEAD_BEEF, 4'b1111, 0, 0, 1'b0, 32'h0);
        do_read (32'h100, 32'hDEAD_BEEF, 0);

        // Single-byte strobe, then a no-op strobe.
        do_write(32'h100, 32'hAA55_AA55, 4'b0010, 0, 1, 1'b0, 32'h0);
        do_read (32'h100, 32'hDEAD_AAEF, 2);
        do_write(32'h100, 32'h1234_5678, 4'b0000, 0, 0, 1'b0, 32'h0);
        do_read (32'h100, 32'hDEAD_AAEF, 0);

        // W three cycles ahead of AW, then AW three cycles ahead of W.
        do_write(32'h204, 32'h1234_5678, 4'b1111, 3, 0, 1'b0, 32'h0);
        do_read (32'h204, 32'h1234_5678, 0);
        do_write(32'h204, 32'h8765_4321, 4'b1111, -3, 0, 1'b0, 32'h0);
        do_read (32'h204, 32'h8765_4321, 1);

        // bready held low with a read waiting; the read goes through afterwards.
        do_write(32'h300, 32'h0BAD_CAFE, 4'b1111, 0, 5, 1'b1, 32'h300);
        do_read (32'h300, 32'h0BAD_CAFE, 0);

        // Address aliasing and ignored byte offset.
        do_write(32'h0002_0100, 32'hCAFE_F00D, 4'b1111, 0, 0, 1'b0, 32'h0);
        do_read (32'h100, 32'hCAFE_F00D, 0);
        do_read (32'h103, 32'hCAFE_F00D, 0);

        // Reset between an accepted AW and its W: the half-write is discarded.
        do_write(32'h200, 32'h1111_1111, 4'b1111, 0, 0, 1'b0, 32'h0);
        axi_awvalid = 1'b1;
        axi_awaddr  = 32'h200;
        #1;
        check("mid_awready", 32'(axi_awready), 32'd1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        #1;
        check("mid_wready",  32'(axi_wready),  32'd1);
        check("mid_awready_busy", 32'(axi_awready), 32'd0);
        resetn     = 1'b0;
        axi_wvalid = 1'b1;
        axi_wdata  = 32'h2222_2222;
        axi_wstrb  = 4'hF;
        #1;
        check_zero("mid_rst_during");
        @(negedge clk);
        resetn     = 1'b1;
        axi_wvalid = 1'b0;
        #1;
        check_zero("mid_rst_after");
        @(negedge clk);
        #1;
        check("mid_idle_arready", 32'(axi_arready), 32'd1);
        check("mid_idle_awready", 32'(axi_awready), 32'd1);
        check("mid_idle_bvalid",  32'(axi_bvalid),  32'd0);
        do_read(32'h200, 32'h1111_1111, 0);

        // Randomized traffic over a small pool of words, addresses aliased at random.
        for (int i = 0; i < 16; i++) begin
            pool[i] = int'($urandom_range(0, 32767));
            do_write(mk_addr(pool[i]), $urandom, 4'b1111,
                     int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)), 1'b0, 32'h0);
        end
        for (int n = 0; n < 60; n++) begin
            a = mk_addr(pool[$urandom_range(0, 15)]);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 3)), 1'b0, 32'h0);
            else
                do_read(a, model[word_of(a)], int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
